// File: rtl/mem_access_unit.sv
// Memory-stage access unit: LW/SW/LR.W/SC.W/AMOSWAP.W over a req/gnt/rvalid data port.
// Define MEM_ACCESS_TIMEOUT_EN to abort a WAIT/AMO_WAIT that sees no mem_rvalid in time.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned RES_GRAN    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_op,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        error
);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StAmoWr, StAmoWait} state_e;

    localparam logic [5:0] OpLw  = 6'd32;
    localparam logic [5:0] OpSw  = 6'd35;
    localparam logic [5:0] OpAmo = 6'd36;
    localparam logic [5:0] OpLr  = 6'd37;
    localparam logic [5:0] OpSc  = 6'd38;

    localparam logic [31:0] GranMask = ~((32'd1 << RES_GRAN) - 32'd1);

    state_e      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] rdata_q, rdata_d;
    logic        res_valid_q, res_valid_d;
    logic [31:0] res_addr_q, res_addr_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        error_q, error_d;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);
    logic [7:0] cnt_q, cnt_d;
`endif

    logic accept, is_legal, aligned, in_res_match, q_res_match;

    function automatic logic gran_match(input logic [31:0] a, input logic [31:0] b);
        return ((a ^ b) & GranMask) == 32'd0;
    endfunction

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        rdata_d     = rdata_q;
        res_valid_d = res_valid_q;
        res_addr_d  = res_addr_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        error_d     = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        in_ready  = (state_q == StIdle);
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;

        accept       = in_valid && in_ready;
        is_legal     = (in_op == OpLw) || (in_op == OpSw) || (in_op == OpAmo) ||
                       (in_op == OpLr) || (in_op == OpSc);
        aligned      = (in_addr[1:0] == 2'b00);
        in_res_match = res_valid_q && gran_match(in_addr, res_addr_q);
        q_res_match  = res_valid_q && gran_match(addr_q, res_addr_q);

        unique case (state_q)
            StIdle: begin
                if (accept && is_legal) begin
                    if (!aligned) begin
                        error_d = 1'b1;
                        if ((in_op == OpLw) || (in_op == OpLr)) begin
                            wb_valid_d = (in_rd != 5'd0);
                            wb_rd_d    = in_rd;
                            wb_data_d  = 32'd0;
                        end
                    end else if ((in_op == OpSc) && !in_res_match) begin
                        // Failed SC resolves without touching memory.
                        wb_valid_d  = (in_rd != 5'd0);
                        wb_rd_d     = in_rd;
                        wb_data_d   = 32'd1;
                        res_valid_d = 1'b0;
                    end else begin
                        op_d    = in_op;
                        addr_d  = in_addr;
                        wdata_d = in_wdata;
                        rd_d    = in_rd;
                        state_d = StReq;
                        if (in_op == OpSc) begin
                            res_valid_d = 1'b0;
                        end
                    end
                end
            end
            StReq: begin
                mem_req   = 1'b1;
                mem_we    = (op_q == OpSw) || (op_q == OpSc);
                mem_addr  = addr_q & 32'hFFFF_FFFC;
                mem_wdata = wdata_q;
                if (mem_gnt) begin
                    state_d = StWait;
`ifdef MEM_ACCESS_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end
            end
            StWait: begin
                if (mem_rvalid) begin
                    state_d = StIdle;
                    unique case (op_q)
                        OpLw, OpLr: begin
                            wb_valid_d = (rd_q != 5'd0);
                            wb_rd_d    = rd_q;
                            wb_data_d  = mem_rdata;
                            if (op_q == OpLr) begin
                                res_valid_d = 1'b1;
                                res_addr_d  = addr_q;
                            end
                        end
                        OpSw: begin
                            if (q_res_match) begin
                                res_valid_d = 1'b0;
                            end
                        end
                        OpSc: begin
                            wb_valid_d = (rd_q != 5'd0);
                            wb_rd_d    = rd_q;
                            wb_data_d  = 32'd0;
                        end
                        OpAmo: begin
                            rdata_d = mem_rdata;
                            state_d = StAmoWr;
                        end
                        default: ;
                    endcase
                end
`ifdef MEM_ACCESS_TIMEOUT_EN
                else if (cnt_q == TimeoutLast) begin
                    state_d     = StIdle;
                    error_d     = 1'b1;
                    res_valid_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            StAmoWr: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q & 32'hFFFF_FFFC;
                mem_wdata = wdata_q;
                if (mem_gnt) begin
                    state_d = StAmoWait;
`ifdef MEM_ACCESS_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end
            end
            StAmoWait: begin
                if (mem_rvalid) begin
                    state_d    = StIdle;
                    wb_valid_d = (rd_q != 5'd0);
                    wb_rd_d    = rd_q;
                    wb_data_d  = rdata_q;
                    if (q_res_match) begin
                        res_valid_d = 1'b0;
                    end
                end
`ifdef MEM_ACCESS_TIMEOUT_EN
                else if (cnt_q == TimeoutLast) begin
                    state_d     = StIdle;
                    error_d     = 1'b1;
                    res_valid_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= 6'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rd_q        <= 5'd0;
            rdata_q     <= 32'd0;
            res_valid_q <= 1'b0;
            res_addr_q  <= 32'd0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'd0;
            error_q     <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            rdata_q     <= rdata_d;
            res_valid_q <= res_valid_d;
            res_addr_q  <= res_addr_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            error_q     <= error_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign error    = error_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: memory responder with random stalls plus an op-level
// reference model (memory array + reservation) checked with immediate assertions.
module tb_mem_access_unit;

    localparam logic [5:0] OpLw  = 6'd32;
    localparam logic [5:0] OpSw  = 6'd35;
    localparam logic [5:0] OpAmo = 6'd36;
    localparam logic [5:0] OpLr  = 6'd37;
    localparam logic [5:0] OpSc  = 6'd38;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;
    logic        mem_req;
    logic        mem_gnt = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        error;

    mem_access_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_addr   (in_addr),
        .in_wdata  (in_wdata),
        .in_rd     (in_rd),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .error     (error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Knobs set by the stimulus, read by the responder.
    bit fast        = 1'b1;
    bit slow_rv     = 1'b0;
    int force_stall = 0;

    // Memory responder state.
    logic [31:0] smem [logic [31:0]];
    int          gnt_count = 0;
    int          stab_viol = 0;
    bit          pend = 1'b0;
    int          rdelay = 0;
    logic [31:0] pend_data = 32'd0;
    bit          counting = 1'b0;
    int          stall_left = 0;
    bit          hold_prev = 1'b0;
    logic [31:0] p_addr, p_wdata;
    logic        p_we;

    // Reference model state.
    logic [31:0] ref_mem [logic [31:0]];
    bit          ref_res_v = 1'b0;
    logic [31:0] ref_res_a = 32'd0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] smem_rd(input logic [31:0] a);
        if (smem.exists(a)) return smem[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    always @(negedge clk) begin
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b0;
        if (pend) begin
            if (rdelay == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend_data;
                pend       = 1'b0;
            end else begin
                rdelay--;
            end
        end
        if (hold_prev && !rst) begin
            if (!(mem_req === 1'b1 && mem_addr === p_addr && mem_we === p_we &&
                  mem_wdata === p_wdata)) stab_viol++;
        end
        hold_prev = 1'b0;
        if (mem_req === 1'b1 && !rst) begin
            if (!counting) begin
                counting   = 1'b1;
                stall_left = fast ? 0 : (force_stall != 0) ? force_stall : $urandom_range(0, 2);
            end
            if (stall_left == 0 && !pend) begin
                mem_gnt  = 1'b1;
                counting = 1'b0;
                gnt_count++;
                if (mem_we) begin
                    smem[mem_addr] = mem_wdata;
                    pend_data      = $urandom;
                end else begin
                    pend_data = smem_rd(mem_addr);
                end
                pend   = 1'b1;
                rdelay = fast ? 0 : slow_rv ? 6 : $urandom_range(0, 2);
            end else begin
                if (stall_left > 0) stall_left--;
                hold_prev = 1'b1;
                p_addr    = mem_addr;
                p_we      = mem_we;
                p_wdata   = mem_wdata;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] w,
                         input logic [4:0] rd, input string tag);
        int k, wb_cnt, err_cnt, g0, exp_g, exp_lat;
        bit done, req1, we1, legal, exp_err, exp_wbv, exp_we1, gm;
        logic [31:0] wb_d, exp_wbd, aw, old;
        logic [4:0] wb_r;
        k = 0;
        while (in_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (in_ready !== 1'b1) begin
            chk({tag, ":ready_wait"}, 32'(in_ready), 32'd1);
            return;
        end
        // Reference outcome of this op.
        legal   = (op == OpLw) || (op == OpSw) || (op == OpAmo) || (op == OpLr) || (op == OpSc);
        aw      = {a[31:2], 2'b00};
        old     = ref_rd(aw);
        gm      = ref_res_v && ((a >> 2) == (ref_res_a >> 2));
        exp_err = 1'b0; exp_wbv = 1'b0; exp_wbd = 32'd0; exp_g = 0; exp_lat = 1; exp_we1 = 1'b0;
        if (legal && a[1:0] != 2'b00) begin
            exp_err = 1'b1;
            exp_wbv = (op == OpLw) || (op == OpLr);
        end else if (legal) begin
            case (op)
                OpLw: begin exp_wbv = 1; exp_wbd = old; exp_g = 1; exp_lat = 3; end
                OpLr: begin
                    exp_wbv = 1; exp_wbd = old; exp_g = 1; exp_lat = 3;
                    ref_res_v = 1'b1; ref_res_a = a;
                end
                OpSw: begin
                    ref_mem[aw] = w; exp_g = 1; exp_lat = 3; exp_we1 = 1;
                    if (gm) ref_res_v = 1'b0;
                end
                OpSc: begin
                    exp_wbv = 1;
                    if (gm) begin
                        ref_mem[aw] = w; exp_wbd = 0; exp_g = 1; exp_lat = 3; exp_we1 = 1;
                    end else begin
                        exp_wbd = 1;
                    end
                    ref_res_v = 1'b0;
                end
                default: begin
                    exp_wbv = 1; exp_wbd = old; ref_mem[aw] = w; exp_g = 2; exp_lat = 5;
                    if (gm) ref_res_v = 1'b0;
                end
            endcase
        end
        exp_wbv = exp_wbv && (rd != 5'd0);

        g0       = gnt_count;
        in_valid = 1'b1; in_op = op; in_addr = a; in_wdata = w; in_rd = rd;
        @(posedge clk);
        k = 0; done = 0; wb_cnt = 0; err_cnt = 0; req1 = 0; we1 = 0; wb_d = 0; wb_r = 0;
        while (!done && k < 300) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                in_valid = 1'b0;
                req1 = mem_req;
                we1  = mem_we;
            end
            if (wb_valid === 1'b1) begin wb_cnt++; wb_d = wb_data; wb_r = wb_rd; end
            if (error === 1'b1) err_cnt++;
            if (in_ready === 1'b1) done = 1;
        end
        // One extra cycle catches late or stretched pulses.
        @(negedge clk);
        if (wb_valid === 1'b1) wb_cnt++;
        if (error === 1'b1) err_cnt++;

        chk({tag, ":done"}, 32'(done), 32'd1);
        chk({tag, ":wb_count"}, 32'(wb_cnt), exp_wbv ? 32'd1 : 32'd0);
        if (exp_wbv) begin
            chk({tag, ":wb_data"}, wb_d, exp_wbd);
            chk({tag, ":wb_rd"}, 32'(wb_r), 32'(rd));
        end
        chk({tag, ":error"}, 32'(err_cnt), exp_err ? 32'd1 : 32'd0);
        chk({tag, ":grants"}, 32'(gnt_count - g0), 32'(exp_g));
        chk({tag, ":mem"}, smem_rd(aw), ref_rd(aw));
        chk({tag, ":req_stable"}, 32'(stab_viol), 32'd0);
        if (fast) begin
            chk({tag, ":latency"}, 32'(k), 32'(exp_lat));
            if (exp_g > 0) begin
                chk({tag, ":req_n1"}, 32'(req1), 32'd1);
                chk({tag, ":we_n1"}, 32'(we1), 32'(exp_we1));
            end
        end
    endtask

    initial begin
        int k, g0, late_wb;
        logic [5:0]  op;
        logic [31:0] a;
        int r;

        rst = 1'b1; in_valid = 1'b0; in_op = 6'd0; in_addr = 32'd0; in_wdata = 32'd0;
        in_rd = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst:in_ready", 32'(in_ready), 32'd1);
        chk("rst:mem_req", 32'(mem_req), 32'd0);
        chk("rst:wb_valid", 32'(wb_valid), 32'd0);
        chk("rst:error", 32'(error), 32'd0);
        chk("rst:wb_data", wb_data, 32'd0);
        rst = 1'b0;

        // Seed memory through the DUT, then the directed scenarios at minimum latency.
        do_op(OpSw, 32'h100, 32'hDEAD_BEEF, 5'd1, "sw_seed100");
        do_op(OpSw, 32'h040, 32'h0000_0011, 5'd0, "sw_seed40");
        do_op(OpLw, 32'h100, 32'd0, 5'd5, "lw100");
        do_op(OpLr, 32'h200, 32'd0, 5'd6, "lr200");
        do_op(OpSc, 32'h200, 32'h55, 5'd6, "sc200_ok");
        do_op(OpSc, 32'h200, 32'h66, 5'd6, "sc200_fail");
        do_op(OpLr, 32'h300, 32'd0, 5'd7, "lr300");
        do_op(OpSw, 32'h300, 32'h77, 5'd7, "sw300");
        do_op(OpSc, 32'h300, 32'h88, 5'd7, "sc300_fail");
        do_op(OpAmo, 32'h040, 32'h22, 5'd8, "amo40");
        do_op(OpLw, 32'h040, 32'd0, 5'd9, "lw40_after_amo");
        do_op(OpSw, 32'h102, 32'h99, 5'd3, "sw_misaligned");
        do_op(OpLw, 32'h106, 32'd0, 5'd3, "lw_misaligned");
        do_op(OpLw, 32'h100, 32'd0, 5'd0, "lw_rd0");
        do_op(6'd33, 32'h100, 32'h1, 5'd2, "illegal_op");

        // Held-off grant on a swap.
        fast = 1'b0; force_stall = 3;
        do_op(OpAmo, 32'h040, 32'h33, 5'd10, "amo40_stall");
        force_stall = 0;

        // Reset while waiting for a read response; the reservation must not survive.
        do_op(OpLr, 32'h280, 32'd0, 5'd4, "lr280");
        slow_rv = 1'b1;
        g0 = gnt_count;
        in_valid = 1'b1; in_op = OpLw; in_addr = 32'h200; in_rd = 5'd3;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (gnt_count == g0 && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("rstwait:granted", 32'(gnt_count - g0), 32'd1);
        @(negedge clk);
        chk("rstwait:busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ref_res_v = 1'b0;
        chk("rstwait:in_ready", 32'(in_ready), 32'd1);
        chk("rstwait:mem_req", 32'(mem_req), 32'd0);
        chk("rstwait:mem_we", 32'(mem_we), 32'd0);
        chk("rstwait:mem_addr", mem_addr, 32'd0);
        chk("rstwait:mem_wdata", mem_wdata, 32'd0);
        chk("rstwait:wb_rd", 32'(wb_rd), 32'd0);
        chk("rstwait:wb_data", wb_data, 32'd0);
        chk("rstwait:error", 32'(error), 32'd0);
        late_wb = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (wb_valid !== 1'b0 || error !== 1'b0 || in_ready !== 1'b1) late_wb++;
        end
        chk("rstwait:late_rvalid_ignored", 32'(late_wb), 32'd0);
        slow_rv = 1'b0;
        do_op(OpSc, 32'h280, 32'hAB, 5'd4, "sc280_after_rst");

        // Random ops over a small word window so reservations collide often.
        for (int n = 0; n < 150; n++) begin
            a = 32'h1000 + 32'($urandom_range(0, 7)) * 32'd4;
            if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
            r = $urandom_range(0, 10);
            case (r)
                0, 1:    op = OpLw;
                2, 3:    op = OpSw;
                4, 5:    op = OpLr;
                6, 7:    op = OpSc;
                8, 9:    op = OpAmo;
                default: op = 6'd0;
            endcase
            do_op(op, a, $urandom, 5'($urandom_range(0, 31)), $sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
